// File: rtl/rand_pkg.sv
// Shared defaults and the per-channel seed derivation for the LFSR card bank.
package rand_pkg;

    localparam logic [15:0] TAP_MASK_DEF   = 16'hB400;
    localparam logic [15:0] SEED_SALT_DEF  = 16'h9E37;
    localparam logic [15:0] RESET_SEED_DEF = 16'hACE1;
    localparam int          CARD_RANGE     = 52;

    // Seed for channel c of a width-w LFSR; an all-zero result would lock the LFSR, so it becomes 1.
    function automatic logic [31:0] seed_for_ch(input logic [31:0] base, input logic [31:0] salt,
                                                input int c, input int w);
        logic [31:0] w_mask;
        logic [31:0] w_seed;
        w_mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        w_seed = (base ^ (salt * 32'(c + 1))) & w_mask;
        if (w_seed == '0) begin
            w_seed = 32'd1;
        end
        return w_seed;
    endfunction

endpackage

// File: rtl/rand_card_bank_if.sv
// Per-channel valid/ready output slots of the card bank.
interface rand_card_bank_if #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 6
);
    logic [NUM_CH-1:0]       rand_ready_in;
    logic [NUM_CH-1:0]       rand_valid_out;
    logic [NUM_CH*OUT_W-1:0] rand_out;

    modport master (input rand_ready_in, output rand_valid_out, output rand_out);
    modport slave  (output rand_ready_in, input rand_valid_out, input rand_out);
endinterface

// File: rtl/rand_lfsr_ch.sv
// One free-running Galois LFSR channel with rejection sampling into a one-entry slot.
module rand_lfsr_ch #(
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAP_MASK    = 16'hB400,
    parameter int                OUT_W       = 6,
    parameter int                RANGE       = 52,
    parameter logic [LFSR_W-1:0] RESET_STATE = 16'h32D6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic [LFSR_W-1:0] o_state,
    output logic              o_reject
);
    logic [LFSR_W-1:0] r_state;
    logic              r_valid;
    logic [OUT_W-1:0]  r_data;

    logic [OUT_W-1:0]  w_cand;
    logic [LFSR_W-1:0] w_next;
    logic              w_accept;
    logic              w_free;
    logic              w_active;
    logic              w_capture;

    assign w_cand    = r_state[OUT_W-1:0];
    assign w_next    = (r_state >> 1) ^ (r_state[0] ? TAP_MASK : '0);
    assign w_accept  = (32'(w_cand) < 32'(RANGE));
    assign w_free    = !r_valid || i_ready;
    assign w_active  = i_enable && !i_seed_load;
    assign w_capture = w_active && w_accept && w_free;
    // Candidates arriving while the slot is full are dropped silently, not counted as rejects.
    assign o_reject  = w_active && w_free && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_seed_load) begin
            r_state <= i_seed;
            r_valid <= 1'b0;
        end else begin
            if (i_enable) begin
                r_state <= w_next;
            end
            if (w_capture) begin
                r_data  <= w_cand;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_state = r_state;
endmodule

// File: rtl/rand_card_bank.sv
// Bank of NUM_CH LFSR channels: seed distribution and a saturating reject counter.
module rand_card_bank
    import rand_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] TAP_MASK   = TAP_MASK_DEF,
    parameter int                OUT_W      = 6,
    parameter int                RANGE      = CARD_RANGE,
    parameter logic [LFSR_W-1:0] SEED_SALT  = SEED_SALT_DEF,
    parameter logic [LFSR_W-1:0] RESET_SEED = RESET_SEED_DEF
) (
    input  logic                       clock_in,
    input  logic                       reset_n_in,
    input  logic                       enable_in,
    input  logic                       seed_load_in,
    input  logic [LFSR_W-1:0]          seed_in,
    rand_card_bank_if.master           rand_if,
    output logic [NUM_CH*LFSR_W-1:0]   raw_out,
    output logic [15:0]                reject_count_out
);
    logic [NUM_CH-1:0] w_reject;
    logic [15:0]       w_pop;
    logic [16:0]       w_sum;
    logic [15:0]       r_count;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [LFSR_W-1:0] RST_ST =
            LFSR_W'(seed_for_ch(32'(RESET_SEED), 32'(SEED_SALT), c, LFSR_W));
        logic [LFSR_W-1:0] w_seed;
        assign w_seed = LFSR_W'(seed_for_ch(32'(seed_in), 32'(SEED_SALT), c, LFSR_W));

        rand_lfsr_ch #(
            .LFSR_W      (LFSR_W),
            .TAP_MASK    (TAP_MASK),
            .OUT_W       (OUT_W),
            .RANGE       (RANGE),
            .RESET_STATE (RST_ST)
        ) u_ch (
            .clk         (clock_in),
            .rst_n       (reset_n_in),
            .i_enable    (enable_in),
            .i_seed_load (seed_load_in),
            .i_seed      (w_seed),
            .i_ready     (rand_if.rand_ready_in[c]),
            .o_valid     (rand_if.rand_valid_out[c]),
            .o_data      (rand_if.rand_out[c*OUT_W +: OUT_W]),
            .o_state     (raw_out[c*LFSR_W +: LFSR_W]),
            .o_reject    (w_reject[c])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_pop = w_pop + 16'(w_reject[c]);
        end
    end

    assign w_sum = {1'b0, r_count} + {1'b0, w_pop};

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_count <= '0;
        end else if (seed_load_in) begin
            r_count <= '0;
        end else if (w_sum[16]) begin
            r_count <= '1;
        end else begin
            r_count <= w_sum[15:0];
        end
    end

    assign reject_count_out = r_count;
endmodule

// File: tb/tb_rand_card_bank.sv
// Directed checks of the card bank against hand-computed LFSR sequences.
module tb_rand_card_bank;
    logic        clock_in;
    logic        reset_n_in;
    logic        enable_in;
    logic        seed_load_in;
    logic [15:0] seed_in;
    logic [63:0] raw_out;
    logic [15:0] reject_count_out;

    int n_total;
    int n_bad;

    rand_card_bank_if #(.NUM_CH(4), .OUT_W(6)) u_if ();

    rand_card_bank u_dut (
        .clock_in         (clock_in),
        .reset_n_in       (reset_n_in),
        .enable_in        (enable_in),
        .seed_load_in     (seed_load_in),
        .seed_in          (seed_in),
        .rand_if          (u_if),
        .raw_out          (raw_out),
        .reject_count_out (reject_count_out)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    function automatic logic [31:0] rnd(input int c);
        return 32'(u_if.rand_out[c*6 +: 6]);
    endfunction

    function automatic logic [31:0] raw(input int c);
        return 32'(raw_out[c*16 +: 16]);
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset_n_in   = 1'b0;
        enable_in    = 1'b0;
        seed_load_in = 1'b0;
        seed_in      = '0;
        u_if.rand_ready_in = 4'hF;

        // Reset state: seeds derived from 16'hACE1
        #12;
        chk("rst_raw0", raw(0), 32'h32D6);
        chk("rst_raw1", raw(1), 32'h908F);
        chk("rst_raw2", raw(2), 32'h7644);
        chk("rst_raw3", raw(3), 32'hD43D);
        chk("rst_valid", 32'(u_if.rand_valid_out), 32'h0);
        chk("rst_rand", 32'(u_if.rand_out), 32'h0);
        chk("rst_cnt", 32'(reject_count_out), 32'h0);

        reset_n_in = 1'b1;
        enable_in  = 1'b1;
        tick();
        chk("e1_rand0", rnd(0), 32'd22);
        chk("e1_rand1", rnd(1), 32'd15);
        chk("e1_rand2", rnd(2), 32'd4);
        chk("e1_valid", 32'(u_if.rand_valid_out), 32'h7);
        chk("e1_cnt", 32'(reject_count_out), 32'd1);
        chk("e1_raw0", raw(0), 32'h196B);
        tick();
        chk("e2_rand0", rnd(0), 32'd43);
        chk("e2_rand1", rnd(1), 32'd7);
        chk("e2_rand2", rnd(2), 32'd34);
        chk("e2_rand3", rnd(3), 32'd30);
        chk("e2_valid", 32'(u_if.rand_valid_out), 32'hF);
        chk("e2_cnt", 32'(reject_count_out), 32'd1);
        chk("e2_raw0", raw(0), 32'hB8B5);

        // Seed load with enable high and full slots being drained; ch0 hits the zero guard
        seed_in      = 16'h9E37;
        seed_load_in = 1'b1;
        tick();
        seed_load_in = 1'b0;
        chk("sl_raw0", raw(0), 32'h0001);
        chk("sl_raw1", raw(1), 32'hA259);
        chk("sl_raw2", raw(2), 32'h4492);
        chk("sl_raw3", raw(3), 32'hE6EB);
        chk("sl_valid", 32'(u_if.rand_valid_out), 32'h0);
        chk("sl_cnt", 32'(reject_count_out), 32'd0);
        chk("sl_rand0", rnd(0), 32'd43);

        tick();
        chk("s1_rand0", rnd(0), 32'd1);
        chk("s1_rand1", rnd(1), 32'd25);
        chk("s1_rand2", rnd(2), 32'd18);
        chk("s1_rand3", rnd(3), 32'd43);
        chk("s1_valid", 32'(u_if.rand_valid_out), 32'hF);
        chk("s1_cnt", 32'(reject_count_out), 32'd0);
        chk("s1_raw0", raw(0), 32'hB400);
        tick();
        chk("s2_rand0", rnd(0), 32'd0);
        chk("s2_rand1", rnd(1), 32'd44);
        chk("s2_rand2", rnd(2), 32'd9);
        chk("s2_valid", 32'(u_if.rand_valid_out), 32'h7);
        chk("s2_cnt", 32'(reject_count_out), 32'd1);
        chk("s2_raw0", raw(0), 32'h5A00);
        tick();
        chk("s3_rand0", rnd(0), 32'd0);
        chk("s3_rand1", rnd(1), 32'd22);
        chk("s3_rand2", rnd(2), 32'd36);
        chk("s3_valid", 32'(u_if.rand_valid_out), 32'h7);
        chk("s3_cnt", 32'(reject_count_out), 32'd2);
        chk("s3_raw0", raw(0), 32'h2D00);

        // Disabled: states frozen, slots held, then drained by ready
        enable_in = 1'b0;
        u_if.rand_ready_in = 4'h0;
        tick();
        tick();
        chk("dis_raw0", raw(0), 32'h2D00);
        chk("dis_valid", 32'(u_if.rand_valid_out), 32'h7);
        chk("dis_rand1", rnd(1), 32'd22);
        u_if.rand_ready_in = 4'hF;
        tick();
        chk("drn_valid", 32'(u_if.rand_valid_out), 32'h0);
        chk("drn_rand1", rnd(1), 32'd22);
        chk("drn_raw0", raw(0), 32'h2D00);
        chk("drn_cnt", 32'(reject_count_out), 32'd2);

        // Seed so ch0 candidate is 60 (rejected)
        enable_in    = 1'b1;
        seed_in      = 16'h9E0B;
        seed_load_in = 1'b1;
        tick();
        seed_load_in = 1'b0;
        chk("rj_raw0", raw(0), 32'h003C);
        chk("rj_raw2", raw(2), 32'h44AE);
        chk("rj_cnt0", 32'(reject_count_out), 32'd0);
        tick();
        chk("rj_cnt1", 32'(reject_count_out), 32'd1);
        chk("rj_valid", 32'(u_if.rand_valid_out), 32'hE);
        chk("rj_rand1", rnd(1), 32'd37);
        chk("rj_rand2", rnd(2), 32'd46);
        chk("rj_rand3", rnd(3), 32'd23);

        // Backpressure for 10 cycles; LFSR keeps running
        u_if.rand_ready_in = 4'h0;
        repeat (10) tick();
        chk("bp_rand2", rnd(2), 32'd46);
        chk("bp_rand0", rnd(0), 32'd30);
        chk("bp_valid", 32'(u_if.rand_valid_out), 32'hF);
        chk("bp_cnt", 32'(reject_count_out), 32'd1);
        chk("bp_raw2", raw(2), 32'hA6AE);

        // Asynchronous reset between edges
        u_if.rand_ready_in = 4'hF;
        #2;
        reset_n_in = 1'b0;
        #1;
        chk("ar_raw0", raw(0), 32'h32D6);
        chk("ar_raw2", raw(2), 32'h7644);
        chk("ar_valid", 32'(u_if.rand_valid_out), 32'h0);
        chk("ar_rand", 32'(u_if.rand_out), 32'h0);
        chk("ar_cnt", 32'(reject_count_out), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
